// File: rtl/tlc5941_pkg.sv
// tlc5941_pkg: shared widths and frame-length helpers for the TLC5941 receiver model.
package tlc5941_pkg;
    localparam int GS_BITS     = 12;
    localparam int DC_BITS     = 6;
    localparam int CH_PER_CHIP = 16;

    function automatic int gs_frame_bits(input int nchips);
        return nchips * CH_PER_CHIP * GS_BITS;
    endfunction

    function automatic int dc_frame_bits(input int nchips);
        return nchips * CH_PER_CHIP * DC_BITS;
    endfunction
endpackage

// File: rtl/tlc5941_pwm.sv
// tlc5941_pwm: grayscale counter and per-channel comparators driving registered LED outputs.
module tlc5941_pwm
    import tlc5941_pkg::*;
#(
    parameter int NCH = 48
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   blank,
    input  logic                   gsclk_rise,
    input  logic [NCH*GS_BITS-1:0] gs_latch,
    output logic [NCH-1:0]         led_out
);
    logic [GS_BITS-1:0] gs_cnt;
    logic [NCH-1:0]     on;

    for (genvar c = 0; c < NCH; c++) begin : g_cmp
        assign on[c] = gs_cnt < gs_latch[GS_BITS*c +: GS_BITS];
    end

    always_ff @(posedge clock) begin
        if (reset || blank)
            gs_cnt <= '0;
        else if (gsclk_rise && gs_cnt != '1)
            gs_cnt <= gs_cnt + 1'b1;
        led_out <= (reset || blank) ? '0 : on;
    end
endmodule

// File: rtl/tlc5941_receiver.sv
// tlc5941_receiver: oversampling far-end model of a TLC5941 chain with GS/DC shift,
// latch, PWM outputs and channel readback.
module tlc5941_receiver
    import tlc5941_pkg::*;
#(
    parameter  int NCHIPS = 3,
    localparam int NCH    = NCHIPS * CH_PER_CHIP,
    localparam int RW     = $clog2(NCH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               led_sclk,
    input  logic               led_sin,
    input  logic               led_mode,
    input  logic               led_xlat,
    input  logic               led_blank,
    input  logic               led_gsclk,
    output logic               led_sout,
    output logic [NCH-1:0]     led_out,
    input  logic [RW-1:0]      rd_ch,
    output logic [GS_BITS-1:0] rd_gs,
    output logic [DC_BITS-1:0] rd_dc,
    output logic               latch_pulse,
    output logic               latch_mode,
    output logic               xlat_err,
    output logic [9:0]         bit_cnt
);
    localparam int         GS_W = gs_frame_bits(NCHIPS);
    localparam int         DC_W = dc_frame_bits(NCHIPS);
    localparam logic [9:0] GS_N = 10'(GS_W);
    localparam logic [9:0] DC_N = 10'(DC_W);

    logic [5:0]      s, p;
    logic [GS_W-1:0] gs_sr, gs_latch;
    logic [DC_W-1:0] dc_sr, dc_latch;
    logic [GS_BITS-1:0] gs_ch [2**RW];
    logic [DC_BITS-1:0] dc_ch [2**RW];

    wire sclk_rise  = s[0] & ~p[0];
    wire sin_s      = s[1];
    wire mode_s     = s[2];
    wire mode_chg   = s[2] ^ p[2];
    wire xlat_rise  = s[3] & ~p[3];
    wire blank_s    = s[4];
    wire gsclk_rise = s[5] & ~p[5];

    // Unused readback slots tie to zero so out-of-range channels read back 0.
    for (genvar c = 0; c < 2**RW; c++) begin : g_ch
        if (c < NCH) begin : g_in
            assign gs_ch[c] = gs_latch[GS_BITS*c +: GS_BITS];
            assign dc_ch[c] = dc_latch[DC_BITS*c +: DC_BITS];
        end else begin : g_out
            assign gs_ch[c] = '0;
            assign dc_ch[c] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s           <= '0;
            p           <= '0;
            gs_sr       <= '0;
            dc_sr       <= '0;
            gs_latch    <= '0;
            dc_latch    <= '0;
            led_sout    <= 1'b0;
            latch_pulse <= 1'b0;
            latch_mode  <= 1'b0;
            xlat_err    <= 1'b0;
            bit_cnt     <= '0;
            rd_gs       <= '0;
            rd_dc       <= '0;
        end else begin
            s           <= {led_gsclk, led_blank, led_xlat, led_mode, led_sin, led_sclk};
            p           <= s;
            latch_pulse <= xlat_rise;
            xlat_err    <= xlat_rise && bit_cnt != (mode_s ? DC_N : GS_N);
            // Latch reads the pre-shift register even when SCLK rises in the same cycle.
            if (xlat_rise) begin
                latch_mode <= mode_s;
                if (mode_s)
                    dc_latch <= dc_sr;
                else
                    gs_latch <= gs_sr;
            end
            if (sclk_rise) begin
                led_sout <= mode_s ? dc_sr[0] : gs_sr[0];
                if (mode_s)
                    dc_sr <= {sin_s, dc_sr[DC_W-1:1]};
                else
                    gs_sr <= {sin_s, gs_sr[GS_W-1:1]};
            end
            bit_cnt <= (xlat_rise || mode_chg) ? '0 :
                       (sclk_rise && bit_cnt != '1) ? bit_cnt + 10'd1 : bit_cnt;
            rd_gs   <= gs_ch[rd_ch];
            rd_dc   <= dc_ch[rd_ch];
        end
    end

    tlc5941_pwm #(.NCH(NCH)) u_pwm (
        .clock      (clock),
        .reset      (reset),
        .blank      (blank_s),
        .gsclk_rise (gsclk_rise),
        .gs_latch   (gs_latch),
        .led_out    (led_out)
    );
endmodule

// File: doc/tlc5941_receiver.md
Name: tlc5941_receiver

Overview:
- Synthesizable receiver model of a TLC5941 daisy chain: the far end of the serial LED interface the pixel driver produces.
- Oversamples led_sclk, led_sin, led_mode, led_xlat, led_blank and led_gsclk on the system clock.
- Rebuilds the grayscale (GS) and dot-correction (DC) shift registers, latches them on XLAT, and generates per-channel PWM from GSCLK/BLANK.
- Used as a loopback checker and in simulation of the LED panel path. It exposes latched data through a channel readback port.

Parameters:
- NCHIPS, 3, number of chained TLC5941 devices (3 = R,G,B banks).
- NCH, NCHIPS*16, derived total channel count.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- led_sclk  in  1  serial data clock, same clock domain, at least 2 clocks high and 2 low.
- led_sin  in  1  serial data.
- led_mode  in  1  1 = DC mode, 0 = GS mode.
- led_xlat  in  1  latch strobe, may be 1 clock wide.
- led_blank  in  1  1 = outputs off and GS counter cleared.
- led_gsclk  in  1  grayscale PWM clock.
- led_sout  out  1  daisy-chain output: bit 0 of the active shift register.
- led_out  out  NCH  channel on/off, 1 = on.
- rd_ch  in  clog2(NCH)  readback channel index.
- rd_gs  out  12  latched GS of rd_ch, 1-clock latency.
- rd_dc  out  6  latched DC of rd_ch, 1-clock latency.
- latch_pulse  out  1  1-clock pulse when any latch occurs.
- latch_mode  out  1  mode of the most recent latch.
- xlat_err  out  1  1-clock pulse when a latch occurs with the wrong bit count.
- bit_cnt  out  10  SCLK rises since the last latch or mode change.

Behaviour:
- Input sampling:
  - Each input is registered (s) and registered again (p).
  - Rise = s & ~p. Each action is taken on the edge where rise is true.
  - Effect is visible two clocks after the input pin rises.
- Shift on SCLK rise:
  - GS mode (sampled mode = 0): gs_sr (NCH*12 bits) <= {sin_s, gs_sr[MSB:1]}.
  - DC mode: dc_sr (NCH*6 bits) <= {sin_s, dc_sr[MSB:1]}.
  - The first bit sent lands in bit 0 after a full frame, so the register equals the transmitter's vector indexed by bit count.
  - The inactive register holds its value.
  - bit_cnt increments and saturates at 1023.
- XLAT rise:
  - Mode 1: dc_latch <= dc_sr. Mode 0: gs_latch <= gs_sr.
  - latch_pulse = 1 and latch_mode = mode; bit_cnt <= 0.
  - xlat_err = 1 if bit_cnt != (mode ? NCH*6 : NCH*12).
  - The latch still occurs on error.
- SCLK rise and XLAT rise in the same cycle:
  - The latch takes the pre-shift register value.
  - The shift still happens.
  - bit_cnt <= 0; that SCLK is not counted.
- Sampled mode change:
  - bit_cnt <= 0. Shift registers are not cleared.
  - No extra SCLK is required on a DC→GS transition.
- PWM counter and outputs:
  - While blank_s = 1: 12-bit gs_cnt <= 0 and led_out = 0.
  - While blank_s = 0: each GSCLK rise increments gs_cnt, saturating at 4095.
  - led_out[c] = ~blank_s & (gs_cnt < gs_latch[12c+11:12c]), registered.
  - GS 0 means the channel is never on. GS 4095 means on for 4095 GSCLKs.
  - DC values do not gate PWM; they are exposed only through readback.
- Readback: rd_gs <= gs_latch[12*rd_ch +: 12], rd_dc <= dc_latch[6*rd_ch +: 6]. An out-of-range rd_ch returns 0.
- led_sout: registered copy of the active register's bit 0 before the shift, updated on each SCLK rise.
- Reset values:
  - All shift registers, latches, counters and sample registers are 0.
  - All outputs are 0. latch_mode = 0.
  - Reset mid-frame discards partial data.

Decomposition:
- Package tlc5941_pkg holds GS_BITS = 12, DC_BITS = 6, CH_PER_CHIP = 16, and the GS_FRAME_BITS and DC_FRAME_BITS functions of NCHIPS.
- One sub-module, tlc5941_pwm: gs_cnt plus the NCH comparators, fed by gs_latch and the blank/gsclk rise signals.

Test Plan:
- DC frame: mode = 1, 288 bits of {16{010000}},{16{010000}},{16{001000}}, then XLAT.
  - latch_pulse with latch_mode = 1, xlat_err = 0.
  - rd_ch = 0 gives rd_dc = 6'b001000; rd_ch = 47 gives 6'b010000.
- GS frame: mode = 0, 576 bits with channel 0 = 12'h00F, all others 0, then XLAT.
  - rd_ch = 0 gives rd_gs = 12'h00F.
  - After BLANK falls, led_out[0] is high for exactly 15 GSCLK rises and then low. Other channels stay low.
- Short frame: XLAT after 575 SCLKs in GS mode.
  - xlat_err pulse, data still latched, bit_cnt returns to 0.
- BLANK mid-PWM: assert BLANK at gs_cnt = 7 with GS = 12'hFFF.
  - led_out drops within 2 clocks and gs_cnt = 0.
  - GSCLK while blanked leaves gs_cnt at 0.
- Coincident SCLK/XLAT rise in one cycle: the latch equals the pre-shift value and bit_cnt = 0 afterwards.
- Reset asserted after 100 GS bits: all outputs 0. A following full frame latches correctly with no xlat_err.
